pipe_stage_buffer: RTL and testbench

- Parametrised elastic pipeline-stage register. Successor to the fixed decode/execute latch; one instance sits between each pair of processor stages (F/D, D/E, E/M, M/W).
- Adds a valid/ready handshake, a 2-entry skid for back-pressure, synchronous flush with bubble insertion, and a configurable payload width.
- Control payload and data payload are separate so a flush or bubble always zeroes the control fields, giving no writes and no branches.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_stage_buffer.sv | 102 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the elastic pipeline-stage buffers.
// Bundle field offsets are used by the per-stage wrappers that pack and unpack bundles.
package pipe_pkg;

  localparam int unsigned CTRL_W_D = 24;
  localparam int unsigned DATA_W_D = 80;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // Control bundle field offsets
  localparam int unsigned CTRL_RW_BIT    = 0;
  localparam int unsigned CTRL_MW_BIT    = 1;
  localparam int unsigned CTRL_MR_BIT    = 2;
  localparam int unsigned CTRL_BR_BIT    = 3;
  localparam int unsigned CTRL_ALUOP_LSB = 4;
  localparam int unsigned CTRL_ALUOP_W   = 6;
  localparam int unsigned CTRL_IMMSEL_LSB = 10;
  localparam int unsigned CTRL_IMMSEL_W  = 3;

  // Data bundle field offsets
  localparam int unsigned DATA_OPA_LSB   = 0;
  localparam int unsigned DATA_OPB_LSB   = 16;
  localparam int unsigned DATA_OP_W      = 16;
  localparam int unsigned DATA_INSN_LSB  = 32;
  localparam int unsigned DATA_INSN_W    = 16;
  localparam int unsigned DATA_PC_LSB    = 48;
  localparam int unsigned DATA_PC_W      = 16;
  localparam int unsigned DATA_RS1_LSB   = 64;
  localparam int unsigned DATA_RS2_LSB   = 69;
  localparam int unsigned DATA_RD_LSB    = 74;
  localparam int unsigned DATA_REG_W     = 5;

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// and synchronous flush that inserts a bubble (control zeroed, data held).
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W  = CTRL_W_D,
  parameter int unsigned DATA_W  = DATA_W_D,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_t      state_q;
  logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0] m_data_q, s_data_q;
  logic              rdy_q;
  logic              accept, emit;

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign occupancy = state_q;
  assign emit      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  if (SKID_EN != 0) begin : g_skid
    assign in_ready = rdy_q;
  end else begin : g_single
    // rdy_q only masks the cycle right after reset in this build.
    assign in_ready = rdy_q && (out_ready || !out_valid);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      rdy_q    <= 1'b0;
    end else if (flush) begin
      // Data is left as-is so downstream sees a clean bubble without extra toggling.
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      rdy_q    <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q  <= ONE;
            m_ctrl_q <= in_ctrl;
            m_data_q <= in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_ctrl_q <= in_ctrl;
            m_data_q <= in_data;
          end else if (accept) begin
            if (SKID_EN != 0) begin
              state_q  <= TWO;
              s_ctrl_q <= in_ctrl;
              s_data_q <= in_data;
              rdy_q    <= 1'b0;
            end
          end else if (emit) begin
            state_q  <= EMPTY;
            m_ctrl_q <= '0;
          end
        end
        TWO: begin
          if (emit) begin
            state_q  <= ONE;
            m_ctrl_q <= s_ctrl_q;
            m_data_q <= s_data_q;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= EMPTY;
          m_ctrl_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench: one skid and one single-entry instance share stimulus; each has its
// own FIFO reference model that tracks accepted beats and flush/reset discards.
module tb_pipe_stage_buffer;

  typedef struct packed {
    logic [23:0] c;
    logic [79:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [23:0] in_ctrl;
  logic [79:0] in_data;

  int          n_chk_all = 0;
  int          n_fail_all = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Skid = (g == 0) ? 1 : 0;

    logic        in_ready, out_valid;
    logic [23:0] out_ctrl;
    logic [79:0] out_data;
    logic [1:0]  occupancy;

    beat_t       q[$];
    logic [79:0] last_d = '0;
    int          since_rst = 0;
    bit          seen = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    pipe_stage_buffer #(
      .CTRL_W (24),
      .DATA_W (80),
      .SKID_EN(Skid)
    ) dut (
      .Clk      (clk),
      .Rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ctrl  (in_ctrl),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ctrl (out_ctrl),
      .out_data (out_data),
      .occupancy(occupancy)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      n_chk_all++;
      if (got !== exp) begin
        n_fail++;
        n_fail_all++;
        $display("FAIL inst%0d %s at %0t: got %h required %h", g, nm, $time, got, exp);
      end
    endtask

    // Model update and emit check: pre-edge values are sampled at the active edge.
    always @(posedge clk) begin
      beat_t b;
      if (rst) begin
        q.delete();
        last_d    = '0;
        since_rst = 0;
        seen      = 1'b1;
      end else begin
        since_rst++;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("emit_unexpected", 128'(1), 128'(0));
          end else begin
            b = q.pop_front();
            chk("emit_beat", 128'({out_ctrl, out_data}), 128'({b.c, b.d}));
          end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{c: in_ctrl, d: in_data});
      end
    end

    // Steady-state output check away from the active edge.
    always @(negedge clk) begin
      logic exp_rdy;
      if (seen) begin
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
        if (q.size() != 0) begin
          chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
          chk("out_data", 128'(out_data), 128'(q[0].d));
          last_d = q[0].d;
        end else begin
          chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
          chk("held_data", 128'(out_data), 128'(last_d));
        end
        if (since_rst == 0) exp_rdy = 1'b0;
        else if (Skid != 0) exp_rdy = (q.size() < 2);
        else exp_rdy = out_ready || (q.size() == 0);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      end
    end
  end

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  task automatic drive(input bit r, input bit v, input bit fl, input bit ordy,
                       input logic [23:0] c);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = c;
    in_data   = rnd80();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = 24'hFFFFFF;
    in_data   = rnd80();

    // Reset held for two edges with a live input beat.
    drive(1, 1, 0, 0, 24'hFFFFFF);
    drive(0, 0, 0, 1, 24'h0);

    // Streaming
    for (int i = 1; i <= 8; i++) drive(0, 1, 0, 1, 24'(i));
    repeat (3) drive(0, 0, 0, 1, 24'h0);

    // Back-pressure: A, B, then C waits until the stage drains.
    drive(0, 1, 0, 0, 24'h0000A1);
    drive(0, 1, 0, 0, 24'h0000B2);
    repeat (3) drive(0, 1, 0, 0, 24'h0000C3);
    repeat (2) drive(0, 1, 0, 1, 24'h0000C3);
    repeat (4) drive(0, 0, 0, 1, 24'h0);

    // Flush while full, with a concurrent beat D that must be dropped.
    drive(0, 1, 0, 0, 24'h0000A4);
    drive(0, 1, 0, 0, 24'h0000B5);
    drive(0, 1, 1, 0, 24'h0000D6);
    drive(0, 0, 0, 0, 24'h0);
    drive(0, 1, 0, 1, 24'h0000E7);
    repeat (3) drive(0, 0, 0, 1, 24'h0);

    // Flush with a concurrent emit.
    drive(0, 1, 0, 0, 24'h0000A8);
    drive(0, 0, 0, 0, 24'h0);
    drive(0, 0, 1, 1, 24'h0);
    repeat (2) drive(0, 0, 0, 1, 24'h0);

    // Continuous stream with out_ready toggling.
    for (int i = 0; i < 40; i++) drive(0, 1, 0, (i % 2) == 0, 24'(100 + i));
    repeat (4) drive(0, 0, 0, 1, 24'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) == 0), $urandom_range(1), ($urandom_range(19) == 0),
            ($urandom_range(3) != 0), 24'($urandom()));
    end
    repeat (4) drive(0, 0, 0, 1, 24'h0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk_all, n_fail_all);
    $finish;
  end

endmodule
